// File: rtl/draw_rect_engine.sv
// Rectangle point generator: walks a rectangle outline clockwise, or rasters it when filled mode is built in.
// Optional filled mode is compiled in with `define DRAW_RECT_FILL_EN.
//
// state  | meaning
// IDLE   | no job, waiting for START
// TOP    | walking row Y_0 toward X_1
// RIGHT  | walking column X_1 toward Y_1
// BOTTOM | walking row Y_1 back toward X_0
// LEFT   | walking column X_0 back toward Y_0, start corner excluded
// RASTER | row-by-row fill, each row X_0 toward X_1
// DONE   | job finished normally, FINISH held
module draw_rect_engine #(
  parameter int CW = 8
) (
  input  logic              ACLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              FILL,
  input  logic [CW-1:0]     X_0,
  input  logic [CW-1:0]     Y_0,
  input  logic [CW-1:0]     X_1,
  input  logic [CW-1:0]     Y_1,
  input  logic              PIX_READY,
  output logic [CW-1:0]     X_Out,
  output logic [CW-1:0]     Y_Out,
  output logic              PIX_VALID,
  output logic              PIX_LAST,
  output logic              BUSY,
  output logic              FINISH,
  output logic [2*CW+1:0]   PIX_CNT
);

  localparam int NW = 2*CW+2;

  typedef enum logic [2:0] {
    IDLE, TOP, RIGHT, BOTTOM, LEFT, RASTER, DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_x0, r_y0, r_x1, r_y1;
  logic [CW-1:0]   r_x, r_y;
  logic [NW-1:0]   r_cnt;
  logic [CW-1:0]   w_x_nxt, w_y_nxt;
  logic [CW-1:0]   w_sx, w_sy;
  logic [CW-1:0]   w_xf, w_xb, w_yf, w_yb;
  logic            w_dx_zero, w_dy_zero;
  logic            w_valid, w_xfer, w_last, w_start;

`ifndef DRAW_RECT_FILL_EN
  logic w_unused_fill;
  assign w_unused_fill = FILL;
`endif

  // Step is +1 toward a larger target, else -1 (all-ones added modulo 2^CW).
  assign w_sx      = (r_x1 > r_x0) ? CW'(1) : {CW{1'b1}};
  assign w_sy      = (r_y1 > r_y0) ? CW'(1) : {CW{1'b1}};
  assign w_xf      = r_x + w_sx;
  assign w_xb      = r_x - w_sx;
  assign w_yf      = r_y + w_sy;
  assign w_yb      = r_y - w_sy;
  assign w_dx_zero = (r_x0 == r_x1);
  assign w_dy_zero = (r_y0 == r_y1);

  assign w_valid = (r_state == TOP) || (r_state == RIGHT) || (r_state == BOTTOM) ||
                   (r_state == LEFT) || (r_state == RASTER);
  assign w_xfer  = w_valid && PIX_READY;

  // A degenerate rectangle ends in TOP (flat) or RIGHT (vertical); otherwise the
  // walk ends one step short of the start corner, which may already be in BOTTOM.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      TOP:          w_last = w_dy_zero && (r_x == r_x1);
      RIGHT:        w_last = w_dx_zero && (r_y == r_y1);
      BOTTOM, LEFT: w_last = (r_x == r_x0) && (w_yb == r_y0);
`ifdef DRAW_RECT_FILL_EN
      RASTER:       w_last = (r_x == r_x1) && (r_y == r_y1);
`endif
      default:      w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_start     = 1'b0;
    if (ABORT) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (START) begin
            w_start     = 1'b1;
`ifdef DRAW_RECT_FILL_EN
            w_state_nxt = FILL ? RASTER : TOP;
`else
            w_state_nxt = TOP;
`endif
          end
        end
        TOP: begin
          if (w_xfer) begin
            if (w_last)            w_state_nxt = DONE;
            else if (r_x != r_x1)  w_x_nxt = w_xf;
            else begin
              w_state_nxt = RIGHT;
              w_y_nxt     = w_yf;
            end
          end
        end
        RIGHT: begin
          if (w_xfer) begin
            if (w_last)            w_state_nxt = DONE;
            else if (r_y != r_y1)  w_y_nxt = w_yf;
            else begin
              w_state_nxt = BOTTOM;
              w_x_nxt     = w_xb;
            end
          end
        end
        BOTTOM: begin
          if (w_xfer) begin
            if (w_last)            w_state_nxt = DONE;
            else if (r_x != r_x0)  w_x_nxt = w_xb;
            else begin
              w_state_nxt = LEFT;
              w_y_nxt     = w_yb;
            end
          end
        end
        LEFT: begin
          if (w_xfer) begin
            if (w_last) w_state_nxt = DONE;
            else        w_y_nxt = w_yb;
          end
        end
`ifdef DRAW_RECT_FILL_EN
        RASTER: begin
          if (w_xfer) begin
            if (w_last)            w_state_nxt = DONE;
            else if (r_x != r_x1)  w_x_nxt = w_xf;
            else begin
              w_x_nxt = r_x0;
              w_y_nxt = w_yf;
            end
          end
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_x0  <= '0;
      r_y0  <= '0;
      r_x1  <= '0;
      r_y1  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_x0  <= X_0;
      r_y0  <= Y_0;
      r_x1  <= X_1;
      r_y1  <= Y_1;
      r_x   <= X_0;
      r_y   <= Y_0;
      r_cnt <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      if (w_xfer && !ABORT && (r_cnt != {NW{1'b1}}))
        r_cnt <= r_cnt + NW'(1);
    end
  end

  assign X_Out     = r_x;
  assign Y_Out     = r_y;
  assign PIX_VALID = w_valid;
  assign PIX_LAST  = w_valid && w_last;
  assign BUSY      = w_valid;
  assign FINISH    = (r_state == DONE);
  assign PIX_CNT   = r_cnt;

endmodule
